// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit
package ifu_pkg;
  localparam int INST_W = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DRAIN, ST_DROP} fetch_state_e;
  function automatic int line_off_w(input int bus_w);
    return $clog2(bus_w / 8);
  endfunction
endpackage

// File: rtl/ifu_inst_fifo.sv
// ifu_inst_fifo: circular instruction FIFO with flush and zeroed head when empty
module ifu_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = flush ? '0 : wr_q + (AW+1)'(do_push);
    rd_d = flush ? '0 : rd_q + (AW+1)'(do_pop);
    head = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/ifu_fetch_buffer.sv
// ifu_fetch_buffer: line-based instruction fetch feeding decode through a FIFO,
// with redirect that flushes and discards any in-flight line.
module ifu_fetch_buffer
  import ifu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int BUS_W = 64,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [BUS_W-1:0]  mem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int OFF = line_off_w(BUS_W);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BUS_W / 8 - 1);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [BUS_W-1:0] line_q, line_d;
  logic [OFF-3:0] idx;
  logic push, full, empty, outstanding;
  logic [INST_W+ADDR_W-1:0] push_data, head;
  always_comb begin
    idx = fetch_pc_q[OFF-1:2];
    push = state_q == ST_DRAIN && (!full || (inst_ready && !empty));
    push_data = {line_q[INST_W*int'(idx) +: INST_W], fetch_pc_q};
    // a response still owed by memory must be swallowed before refetching
    outstanding = (state_q == ST_WAIT || state_q == ST_DROP) && !mem_resp_valid;
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    line_d = line_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~ADDR_W'(3);
      state_d = (outstanding || (state_q == ST_REQ && mem_req_ready)) ? ST_DROP : ST_REQ;
    end else begin
      unique case (state_q)
        ST_REQ: state_d = mem_req_ready ? ST_WAIT : ST_REQ;
        ST_WAIT: begin
          line_d = mem_resp_valid ? mem_resp_data : line_q;
          state_d = mem_resp_valid ? ST_DRAIN : ST_WAIT;
        end
        ST_DRAIN: begin
          fetch_pc_d = push ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
          state_d = (push && &idx) ? ST_REQ : ST_DRAIN;
        end
        default: state_d = mem_resp_valid ? ST_REQ : ST_DROP;
      endcase
    end
    mem_req_valid = reset && state_q == ST_REQ;
    mem_req_addr = reset ? fetch_pc_q & ~LINE_MASK : '0;
    inst_valid = reset && !empty;
    {inst, inst_pc} = head;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      line_q <= line_d;
    end
  end
  ifu_inst_fifo #(.DEPTH(DEPTH), .W(INST_W + ADDR_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(redirect_valid),
    .push(push),
    .push_data(push_data),
    .pop(inst_ready),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// tb_ifu_fetch_buffer: randomized fetch bench with a memory model and an
// in-order PC/instruction scoreboard.
module tb_ifu_fetch_buffer;
  localparam int ADDR_W = 64;
  localparam int BUS_W = 128;
  localparam int DEPTH = 4;
  localparam int N = BUS_W / 32;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  typedef struct {logic [63:0] pc; logic [31:0] inst;} exp_t;
  logic clk = 0;
  logic reset = 0;
  logic mem_req_valid, mem_req_ready = 0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic mem_resp_valid = 0;
  logic [BUS_W-1:0] mem_resp_data = '0;
  logic redirect_valid = 0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic inst_valid, inst_ready = 0;
  logic [31:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  int checks = 0, errors = 0, req_count = 0, pops = 0, bad_seen = 0, idle = 0, dly = 1;
  int pend_cnt;
  bit pend = 0, pend_stale = 0, nxt_valid = 0, prev_redir = 0, prev_hold = 0;
  logic [63:0] pend_addr, last_req_addr, next_exp = RESET_PC, prev_addr;
  exp_t sb[$];
  ifu_fetch_buffer #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0F0F_1234;
  endfunction
  function automatic logic [63:0] line_of(input logic [63:0] a);
    return a & ~64'(BUS_W / 8 - 1);
  endfunction
  function automatic logic [BUS_W-1:0] make_line(input logic [63:0] a, input bit stale);
    logic [BUS_W-1:0] d;
    for (int k = 0; k < N; k++) d[32*k +: 32] = stale ? 32'hDEAD_BEEF : word(a + 64'(4 * k));
    return d;
  endfunction
  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // memory: one outstanding read, fixed delay chosen at accept; feeds the scoreboard
  always @(negedge clk) begin : mem_model
    logic [63:0] p;
    exp_t e;
    nxt_valid = 0;
    if (!reset) begin
      pend = 0;
      sb.delete();
      next_exp = RESET_PC;
    end else begin
      if (mem_resp_valid && pend) begin
        if (!pend_stale && !redirect_valid) begin
          p = next_exp;
          do begin
            e.pc = p;
            e.inst = word(p);
            sb.push_back(e);
            p = p + 64'd4;
          end while (line_of(p) == line_of(next_exp));
          next_exp = p;
        end
        pend = 0;
      end
      if (mem_req_valid && mem_req_ready) begin
        chk(!pend, "one_outstanding", 64'(pend), 0);
        if (!redirect_valid) chk(mem_req_addr == line_of(next_exp), "req_addr", mem_req_addr, line_of(next_exp));
        pend = 1;
        pend_cnt = dly;
        pend_stale = redirect_valid;
        pend_addr = mem_req_addr;
        last_req_addr = mem_req_addr;
        req_count++;
      end
      if (redirect_valid) begin
        sb.delete();
        next_exp = redirect_pc & ~64'h3;
        if (pend) pend_stale = 1;
      end
      if (pend) begin
        pend_cnt--;
        nxt_valid = pend_cnt == 0;
      end
    end
  end
  always @(posedge clk) begin
    #1;
    mem_resp_valid = nxt_valid;
    mem_resp_data = nxt_valid ? make_line(pend_addr, pend_stale) : '0;
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && prev_redir) chk(!inst_valid, "valid_after_redirect", 64'(inst_valid), 0);
    if (reset && prev_hold) chk(mem_req_valid && mem_req_addr == prev_addr, "req_hold", mem_req_addr, prev_addr);
    if (reset && inst_valid && inst == 32'hDEAD_BEEF) bad_seen++;
    if (reset && inst_valid && inst_ready && !redirect_valid) begin
      idle = 0;
      pops++;
      chk(sb.size() != 0, "inst_unexpected", inst_pc, 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(inst_pc == e.pc, "inst_pc", inst_pc, e.pc);
        chk(inst == e.inst, "inst_data", 64'(inst), 64'(e.inst));
      end
    end else if (reset && inst_ready) begin
      idle++;
      if (idle >= 200) begin
        checks++;
        errors++;
        $display("FAIL watchdog: got no instruction for %0d cycles, expected progress", idle);
        idle = 0;
      end
    end
    prev_redir = reset && redirect_valid;
    prev_hold = reset && mem_req_valid && !mem_req_ready && !redirect_valid;
    prev_addr = mem_req_addr;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_req(input logic [63:0] a, input string name);
    int n, t;
    n = req_count;
    t = 0;
    while (req_count == n && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk(req_count != n, {name, "_seen"}, 64'(t), 40);
    if (req_count != n) chk(last_req_addr == a, name, last_req_addr, a);
  endtask
  task automatic stall_at(input logic [63:0] a);
    step();
    redirect_valid = 1;
    redirect_pc = a;
    inst_ready = 0;
    mem_req_ready = 1;
    dly = 1;
    step();
    redirect_valid = 0;
    repeat (30) step();
  endtask
  initial begin
    int rc, p0, t;
    inst_ready = 1;
    mem_req_ready = 1;
    repeat (3) step();
    @(negedge clk);
    chk(!mem_req_valid, "rst_req_valid", 64'(mem_req_valid), 0);
    chk(!inst_valid, "rst_inst_valid", 64'(inst_valid), 0);
    chk(inst == 0 && inst_pc == 0, "rst_inst", inst_pc, 0);
    chk(mem_req_addr == 0, "rst_addr", mem_req_addr, 0);
    step();
    reset = 1;
    @(negedge clk);
    chk(mem_req_valid && mem_req_addr == RESET_PC, "first_req", mem_req_addr, RESET_PC);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    chk(!inst_valid, "latency_early", 64'(inst_valid), 0);
    step();
    @(negedge clk);
    chk(inst_valid && inst_pc == RESET_PC, "latency_first", inst_pc, RESET_PC);
    repeat (40) step();
    redirect_valid = 1;
    redirect_pc = 64'h8000_010A;
    step();
    redirect_valid = 0;
    wait_req(64'h8000_0100, "redir_line_req");
    wait_req(64'h8000_0110, "redir_next_req");
    repeat (20) step();
    stall_at(64'h8000_1000);
    rc = req_count;
    repeat (10) step();
    @(negedge clk);
    chk(req_count == rc && !mem_req_valid, "stall_no_req", 64'(req_count), 64'(rc));
    chk(inst_valid && inst_pc == 64'h8000_1000, "stall_head", inst_pc, 64'h8000_1000);
    step();
    inst_ready = 1;
    p0 = pops;
    repeat (4) step();
    chk(pops - p0 == 4, "release_burst", 64'(pops - p0), 4);
    repeat (20) step();
    stall_at(64'h8000_1000);
    inst_ready = 1;
    redirect_valid = 1;
    redirect_pc = 64'h8000_3004;
    @(negedge clk);
    chk(inst_valid, "full_before_flush", 64'(inst_valid), 1);
    step();
    redirect_valid = 0;
    @(negedge clk);
    chk(!inst_valid, "flush_empty", 64'(inst_valid), 0);
    repeat (20) step();
    dly = 4;
    bad_seen = 0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(mem_req_valid && mem_req_ready) && t < 40);
    step();
    redirect_valid = 1;
    redirect_pc = 64'h8000_2000;
    step();
    redirect_valid = 0;
    wait_req(64'h8000_2000, "drop_req");
    repeat (20) step();
    chk(bad_seen == 0, "stale_data_seen", 64'(bad_seen), 0);
    stall_at(64'h8000_1000);
    reset = 0;
    mem_req_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk(!mem_req_valid && !inst_valid, "mid_reset_quiet", 64'({mem_req_valid, inst_valid}), 0);
      step();
    end
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk(mem_req_valid && mem_req_addr == RESET_PC, "post_reset_req", mem_req_addr, RESET_PC);
      step();
    end
    mem_req_ready = 1;
    inst_ready = 1;
    repeat (30) step();
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 499) != 0;
      mem_req_ready = $urandom_range(0, 9) < 7;
      inst_ready = $urandom_range(0, 9) < 6;
      dly = $urandom_range(1, 4);
      redirect_valid = $urandom_range(0, 99) < 3;
      case ($urandom_range(0, 3))
        0: redirect_pc = 64'h8000_0000 + 64'($urandom_range(0, 4095));
        1: redirect_pc = {32'hFFFF_FFFF, 32'hFFFF_FFE0 + 32'($urandom_range(0, 31))};
        default: redirect_pc = 64'h8001_0000 + 64'($urandom_range(0, 255));
      endcase
      step();
    end
    reset = 1;
    redirect_valid = 0;
    inst_ready = 1;
    mem_req_ready = 1;
    repeat (20) step();
    chk(pops > 500, "throughput", 64'(pops), 500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu_fetch_buffer.md
Name: ifu_fetch_buffer

Overview:
- Parametrised successor to the single-cycle instruction fetch path.
- Issues line-aligned memory read requests over a valid/ready bus of configurable width and extracts the 32-bit instructions from each returned line.
- Buffers the extracted instructions in a DEPTH-entry FIFO and presents them to decode with valid/ready, tagged with their PC.
- Supports redirect (branch/exception flush) at any cycle, including while a memory response is outstanding.

Parameters:
- ADDR_W, 64, PC and memory address width.
- BUS_W, 64, memory read data width in bits; legal values 64, 128, 256. INSTS_PER_LINE = BUS_W/32.
- DEPTH, 4, instruction FIFO entries; power of two, at least 2.
- RESET_PC, 64'h8000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low (reset==0 resets on the next posedge).
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  line-aligned address (low log2(BUS_W/8) bits zero).
- mem_resp_valid  in  1  read data valid; exactly one response per accepted request; the block is always ready for it.
- mem_resp_data  in  BUS_W  line data; instruction k is bits [32k+31:32k].
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] ignored (treated as 0).
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode consumes the head.
- inst  out  32  head instruction.
- inst_pc  out  ADDR_W  head PC.

Behaviour:
- Reset:
  - state=REQ, fetch_pc=RESET_PC, FIFO empty.
  - mem_req_valid=0 during reset and asserted from the first cycle after reset is released.
  - inst_valid=0, inst=0, inst_pc=0, mem_req_addr=0.
- State machine REQ / WAIT / DRAIN / DROP:
  - REQ: mem_req_valid=1, mem_req_addr=fetch_pc with low line bits cleared. On mem_req_ready go to WAIT. Addr is held stable while valid && !ready.
  - WAIT: on mem_resp_valid, latch data into the line register; idx=fetch_pc[log2(BUS_W/8)-1:2]; go to DRAIN.
  - DRAIN: each cycle the FIFO is not full (or is popped the same cycle), push {line[idx], fetch_pc}; then fetch_pc+=4 and idx+=1. After pushing idx==INSTS_PER_LINE-1, go to REQ. The next request is for the following line (wrap-around of idx to a new line).
  - DROP: entered when a redirect hits while in WAIT. Wait for mem_resp_valid, discard the data, go to REQ.
- Redirect has the highest priority, same cycle:
  - Clear the FIFO (a same-cycle pop or push is ignored).
  - fetch_pc = {redirect_pc[ADDR_W-1:2],2'b00}.
  - Next state: from WAIT -> DROP; from REQ, if the request is accepted this cycle -> DROP; from REQ not accepted, DRAIN, or DROP -> REQ or DROP respectively. DROP stays DROP until the outstanding response arrives.
  - inst_valid=0 the cycle after a redirect.
- FIFO:
  - Circular, with pointers of log2(DEPTH)+1 bits.
  - Simultaneous push and pop when full is allowed: the pop frees the slot.
  - Pop when empty is ignored.
  - inst/inst_pc are registered outputs from the head; no combinational path from mem_resp_data to inst.
- Latency:
  - Request accepted at cycle t, response at t+k: first instruction visible at inst_valid at t+k+2 (latch, then push).
  - Steady state is one instruction per cycle from a line.
- Arithmetic: fetch_pc wraps modulo 2^ADDR_W. At most one outstanding request.

Decomposition:
- Shared package ifu_pkg: fetch state enum (REQ, WAIT, DRAIN, DROP), INST_W=32, RESET_PC default, line-offset width function.
- One natural sub-module: ifu_inst_fifo, a parametrised DEPTH x (32+ADDR_W) synchronous FIFO with a flush input.

Test Plan:
- Reset then free-running memory (ready=1, 1-cycle response), BUS_W=64, inst_ready=1 -> requests at 0x8000_0000, 0x8000_0008, ...; inst_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; inst equals the matching halves of the returned data.
- BUS_W=128, redirect_pc=0x8000_0108 -> first request addr 0x8000_0100; pushes only words 2 and 3 (pc 0x108, 0x10C); next request 0x8000_0110.
- inst_ready=0 with DEPTH=4 -> exactly 4 entries buffered, DRAIN stalls, no new request. Then raise inst_ready -> order is preserved and there is no duplicate or lost PC.
- Redirect to 0x8000_2000 while in WAIT; old response returns 3 cycles later with 0xDEADBEEF -> data never appears on inst; next request addr 0x8000_2000.
- Redirect in the same cycle as a pop and a push with a full FIFO -> FIFO empty next cycle, inst_valid=0.
- reset driven low mid-DRAIN with mem_req_ready=0 for 3 cycles -> mem_req_valid=0 and inst_valid=0 while reset is asserted; after release, a request to 0x8000_0000 with the address stable until accepted.
